// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: request, function-unit drive/return and result/status bundle
interface alu_op_sequencer_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] a, b, y;
    logic             c, v;
    logic [1:0]       osel, fsel;
    logic [WIDTH-1:0] opa, opb;
    logic             cin;
    logic [WIDTH-1:0] result;
    logic             cf, vf, zf, nf, busy, done, err;
    modport master (
        output start, opcode, a, b, y, c, v,
        input  osel, fsel, opa, opb, cin, result, cf, vf, zf, nf, busy, done, err
    );
    modport slave (
        input  start, opcode, a, b, y, c, v,
        output osel, fsel, opa, opb, cin, result, cf, vf, zf, nf, busy, done, err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives external add/shift/logic units, iterating shifts one bit per cycle
module alu_op_sequencer #(
    parameter int WIDTH = 8
) (
    input logic               clk_i,
    input logic               rst_i,
    alu_op_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, EXEC, ITER, WB} state_e;
    state_e           state_q;
    logic [1:0]       osel_q, fsel_q;
    logic [WIDTH-1:0] opa_q, opb_q, result_q;
    logic [CW-1:0]    cnt_q;
    logic             cin_q, cf_q, vf_q, zf_q, nf_q, busy_q, done_q, err_q;
    logic             legal, shift, fin, pass;
    logic [CW-1:0]    n_d;
    logic [WIDTH-1:0] res_d;
    logic             c_d, v_d;
    always_comb begin
        legal = bus.opcode[3:2] == 2'b10 || (!bus.opcode[3] && bus.opcode[1:0] != 2'b11);
        shift = bus.opcode[3:2] == 2'b01;
        n_d   = bus.b[CW-1:0];
        fin   = state_q == EXEC || (state_q == ITER && cnt_q == CW'(1));
        // a zero-count shift lands in EXEC and returns OPA untouched
        pass  = state_q == EXEC && osel_q == 2'b01;
        res_d = pass ? opa_q : bus.y;
        c_d   = pass ? 1'b0 : bus.c;
        v_d   = pass ? 1'b0 : bus.v;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            osel_q   <= '0;
            fsel_q   <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            cin_q    <= 1'b0;
            result_q <= '0;
            cf_q     <= 1'b0;
            vf_q     <= 1'b0;
            zf_q     <= 1'b0;
            nf_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (fin) begin
                result_q <= res_d;
                cf_q     <= c_d;
                vf_q     <= v_d;
                zf_q     <= res_d == '0;
                nf_q     <= res_d[WIDTH-1];
                done_q   <= 1'b1;
            end
            case (state_q)
                IDLE: if (bus.start) begin
                    if (legal) begin
                        osel_q  <= bus.opcode[3:2];
                        fsel_q  <= bus.opcode[1:0];
                        opa_q   <= bus.a;
                        opb_q   <= bus.b;
                        cin_q   <= bus.opcode == 4'b0010 && cf_q;
                        cnt_q   <= n_d;
                        busy_q  <= 1'b1;
                        state_q <= (shift && n_d != '0) ? ITER : EXEC;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                EXEC: state_q <= WB;
                ITER: begin
                    opa_q   <= bus.y;
                    cnt_q   <= cnt_q - CW'(1);
                    state_q <= cnt_q == CW'(1) ? WB : ITER;
                end
                WB: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign bus.osel   = osel_q;
    assign bus.fsel   = fsel_q;
    assign bus.opa    = opa_q;
    assign bus.opb    = opb_q;
    assign bus.cin    = cin_q;
    assign bus.result = result_q;
    assign bus.cf     = cf_q;
    assign bus.vf     = vf_q;
    assign bus.zf     = zf_q;
    assign bus.nf     = nf_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: vector table, corner sequences and random ops against a reference model
module tb_alu_op_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    alu_op_sequencer_if #(.WIDTH(8)) bif ();
    alu_op_sequencer #(.WIDTH(8)) dut (.clk_i(clk), .rst_i(rst), .bus(bif));
    always #5 clk = ~clk;
    logic [8:0] sum;
    logic [7:0] ob;
    always_comb begin
        ob    = bif.fsel == 2'b01 ? ~bif.opb : bif.opb;
        sum   = {1'b0, bif.opa} + {1'b0, ob} + {8'd0, bif.fsel == 2'b01 ? 1'b1 : bif.cin};
        bif.y = 8'h00;
        bif.c = 1'b0;
        bif.v = 1'b0;
        if (bif.osel == 2'b00) begin
            bif.y = sum[7:0];
            bif.c = sum[8];
            bif.v = (bif.opa[7] == ob[7]) && (sum[7] != bif.opa[7]);
        end else if (bif.osel == 2'b01) begin
            bif.y = bif.fsel == 2'b00 ? {bif.opa[6:0], 1'b0} :
                    bif.fsel == 2'b01 ? {1'b0, bif.opa[7:1]} : {bif.opa[7], bif.opa[7:1]};
            bif.c = bif.fsel == 2'b00 ? bif.opa[7] : bif.opa[0];
            bif.v = bif.fsel == 2'b00 && (bif.opa[7] ^ bif.opa[6]);
        end else if (bif.osel == 2'b10) begin
            bif.y = bif.fsel == 2'b00 ? bif.opa & bif.opb :
                    bif.fsel == 2'b01 ? bif.opa | bif.opb :
                    bif.fsel == 2'b10 ? bif.opa ^ bif.opb : ~bif.opa;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [3:0] op, input logic [7:0] a, b, input logic cfi,
                                  output logic [7:0] r, output logic c, v, output int lat,
                                  output logic ill);
        int sa, sb, s, n;
        logic [7:0] x;
        sa = int'($signed(a));
        sb = int'($signed(b));
        n = int'(b[2:0]);
        ill = 1'b0; c = 1'b0; v = 1'b0; lat = 2; r = 8'h00; x = 8'h00;
        case (op)
            4'h0: begin s = int'(a) + int'(b); r = 8'(s); c = s > 255; v = sa + sb > 127 || sa + sb < -128; end
            4'h1: begin r = a - b; c = a >= b; v = sa - sb > 127 || sa - sb < -128; end
            4'h2: begin
                s = int'(a) + int'(b) + int'(cfi); r = 8'(s); c = s > 255;
                v = sa + sb + int'(cfi) > 127 || sa + sb + int'(cfi) < -128;
            end
            4'h4, 4'h5, 4'h6: begin
                if (n == 0) r = a;
                else begin
                    lat = n + 1;
                    if (op == 4'h4) begin
                        r = 8'(a << n); x = 8'(a << (n - 1)); c = x[7]; v = x[7] ^ x[6];
                    end else if (op == 4'h5) begin
                        r = a >> n; x = a >> (n - 1); c = x[0];
                    end else begin
                        r = 8'($signed(a) >>> n); x = 8'($signed(a) >>> (n - 1)); c = x[0];
                    end
                end
            end
            4'h8: r = a & b;
            4'h9: r = a | b;
            4'hA: r = a ^ b;
            4'hB: r = ~a;
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a, b,
                          input logic [7:0] er, input logic ec, ev, ez, en, ecin,
                          input int elat, input logic eerr);
        int lat;
        bif.start = 1'b1; bif.opcode = op; bif.a = a; bif.b = b;
        tick();
        bif.start = 1'b0;
        chk({tag, " err"}, bif.err, eerr);
        chk({tag, " busy"}, bif.busy, !eerr);
        if (eerr) begin
            chk({tag, " keep"}, {bif.result, bif.cf, bif.vf, bif.zf, bif.nf}, {er, ec, ev, ez, en});
            tick();
            chk({tag, " err pulse"}, bif.err, 1'b0);
        end else begin
            chk({tag, " sel"}, {bif.osel, bif.fsel}, op);
            chk({tag, " opb"}, bif.opb, b);
            chk({tag, " cin"}, bif.cin, ecin);
            lat = 1;
            while (!bif.done && lat < 40) begin
                tick();
                lat++;
            end
            chk({tag, " latency"}, lat, elat);
            chk({tag, " result"}, bif.result, er);
            chk({tag, " flags"}, {bif.cf, bif.vf, bif.zf, bif.nf}, {ec, ev, ez, en});
            tick();
            chk({tag, " idle"}, {bif.busy, bif.done}, 2'b00);
        end
    endtask

    typedef struct {
        logic [3:0] op;
        logic [7:0] a, b, r;
        logic       c, v, z, n, cin;
        int         lat;
        logic       err;
    } vec_t;
    vec_t vt[16];

    initial begin
        logic [7:0] m_r, r;
        logic       m_c, m_v, m_z, m_n, c, v, ill;
        int         lat, dones, errs;
        logic [3:0] op;
        logic [7:0] a, b;
        vt = '{
            '{4'h0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2, 1'b0},
            '{4'h4, 8'h81, 8'h03, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0},
            '{4'h1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b0},
            '{4'h2, 8'h10, 8'h20, 8'h31, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0},
            '{4'h5, 8'hA5, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0},
            '{4'hF, 8'h12, 8'h34, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1},
            '{4'h6, 8'h80, 8'h02, 8'hE0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3, 1'b0},
            '{4'h5, 8'h03, 8'h01, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0},
            '{4'h8, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0},
            '{4'h9, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b0},
            '{4'hA, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0},
            '{4'hB, 8'h0F, 8'h99, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0},
            '{4'h4, 8'h01, 8'h07, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8, 1'b0},
            '{4'h0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b0},
            '{4'h2, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0},
            '{4'h1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 1'b0}
        };
        bif.start = 1'b0; bif.opcode = 4'h0; bif.a = 8'h00; bif.b = 8'h00;
        tick();
        tick();
        chk("reset state", {bif.osel, bif.fsel, bif.opa, bif.opb, bif.cin, bif.result, bif.cf,
                            bif.vf, bif.zf, bif.nf, bif.busy, bif.done, bif.err}, 36'd0);
        rst = 1'b0;
        // iterated shift: OPA walks through each single-bit step
        bif.start = 1'b1; bif.opcode = 4'h4; bif.a = 8'h81; bif.b = 8'h03;
        tick();
        bif.start = 1'b0;
        chk("shl opa c1", bif.opa, 8'h81);
        tick();
        chk("shl opa c2", bif.opa, 8'h02);
        tick();
        chk("shl opa c3", bif.opa, 8'h04);
        tick();
        chk("shl done c4", {bif.done, bif.result, bif.cf}, {1'b1, 8'h08, 1'b0});
        tick();
        for (int i = 0; i < 16; i++)
            run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].r, vt[i].c, vt[i].v,
                   vt[i].z, vt[i].n, vt[i].cin, vt[i].lat, vt[i].err);
        // START held high through a 5-step shift, including its WB cycle
        bif.start = 1'b1; bif.opcode = 4'h4; bif.a = 8'h01; bif.b = 8'h05;
        tick();
        dones = 0;
        errs = 0;
        for (int k = 1; k <= 6; k++) begin
            bif.opcode = k[0] ? 4'hF : 4'h0;
            bif.a = 8'hFF;
            bif.b = 8'hFF;
            dones += int'(bif.done);
            errs += int'(bif.err);
            tick();
        end
        bif.start = 1'b0;
        dones += int'(bif.done);
        errs += int'(bif.err);
        chk("hold start dones", dones, 1);
        chk("hold start errs", errs, 0);
        chk("hold start idle after wb", bif.busy, 1'b0);
        chk("hold start opb", bif.opb, 8'h05);
        chk("hold start result", bif.result, 8'h20);
        tick();
        // reset in the second ITER cycle aborts the shift
        bif.start = 1'b1; bif.opcode = 4'h5; bif.a = 8'hF0; bif.b = 8'h07;
        tick();
        bif.start = 1'b0;
        chk("abort busy c1", bif.busy, 1'b1);
        tick();
        rst = 1'b1;
        tick();
        chk("abort clears", {bif.osel, bif.fsel, bif.opa, bif.opb, bif.cin, bif.result, bif.cf,
                             bif.vf, bif.zf, bif.nf, bif.busy, bif.done, bif.err}, 36'd0);
        rst = 1'b0;
        run_op("post-rst add", 4'h0, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b0);
        m_r = 8'h46; m_c = 1'b0; m_v = 1'b0; m_z = 1'b0; m_n = 1'b0;
        for (int i = 0; i < 200; i++) begin
            op = 4'($urandom_range(0, 15));
            a = 8'($urandom);
            b = 8'($urandom);
            model(op, a, b, m_c, r, c, v, lat, ill);
            if (ill) begin
                run_op($sformatf("rnd%0d", i), op, a, b, m_r, m_c, m_v, m_z, m_n, 1'b0, 0, 1'b1);
            end else begin
                run_op($sformatf("rnd%0d", i), op, a, b, r, c, v, r == 8'h00, r[7],
                       op == 4'h2 ? m_c : 1'b0, lat, 1'b0);
                m_r = r; m_c = c; m_v = v; m_z = r == 8'h00; m_n = r[7];
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
